ps2_mouse_ctrl: RTL and testbench

Power-up and recovery sequencer for the PS/2 mouse link. It drives the host-to-device transmitter through the init sequence: reset (0xFF), wait for ACK 0xFA, self-test pass 0xAA and ID 0x00, then enable streaming (0xF4) and wait for ACK 0xFA. While initialising, it holds the downstream packet assembler off by gating the receive strobe. It handles timeouts, resend requests and bounded retries, and reports status to the system.

---
 rtl/ps2_mouse_ctrl_pkg.sv | 23 ++
 rtl/ps2_mouse_ctrl_if.sv | 22 ++
 rtl/ps2_mouse_ctrl_timeout_cnt.sv | 27 ++
 rtl/ps2_mouse_ctrl.sv | 131 +++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_mouse_ctrl_pkg.sv
// Shared PS/2 mouse command/response bytes and the init sequencer state encoding.
package ps2_mouse_ctrl_pkg;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_EN_STREAM = 8'hF4;
  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_RESEND    = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL  = 8'hFC;
  localparam logic [7:0] RSP_ID        = 8'h00;

  typedef enum logic [2:0] {
    StPowerup,
    StSend,
    StWaitTx,
    StWaitAck,
    StWaitBat,
    StWaitId,
    StStream,
    StError
  } state_e;

endpackage

// File: rtl/ps2_mouse_ctrl_if.sv
// Transmitter/receiver handshake between the init sequencer and the PS/2 link.
interface ps2_mouse_ctrl_if;

  logic       tx_ready;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_done_pkt;

  modport master (
    input  tx_ready, tx_done, rx_done, rx_data,
    output tx_start, tx_data, rx_done_pkt
  );

  modport slave (
    output tx_ready, tx_done, rx_done, rx_data,
    input  tx_start, tx_data, rx_done_pkt
  );

endinterface

// File: rtl/ps2_mouse_ctrl_timeout_cnt.sv
// Loadable down-counter; expire is high while the count sits at zero.
module ps2_mouse_ctrl_timeout_cnt #(
  parameter int unsigned      Width    = 32,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             expire
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= ResetVal;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse power-up/recovery sequencer: reset, BAT/ID check, enable streaming,
// with timeouts, resend handling and bounded retries.
module ps2_mouse_ctrl
  import ps2_mouse_ctrl_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  ps2_mouse_ctrl_if.master link,
  output logic             stream_en,
  output logic             init_error,
  output logic [1:0]       retry_cnt
);

  localparam logic [1:0] RetryMax  = 2'(MAX_RETRY);
  localparam logic [1:0] RetryLast = 2'(MAX_RETRY - 1);

  state_e     state_q;
  logic [7:0] cmd_q, tx_data_q;
  logic       tx_start_q, stream_en_q, init_error_q, load_q;
  logic [1:0] retry_q;
  logic       expire, waiting, timed_out, resend, fail, give_up;

  // Timer reload is registered, so the counter lands one cycle late; it is loaded with
  // TIMEOUT_CYCLES-2 and its stale value is masked during the reload cycle.
  ps2_mouse_ctrl_timeout_cnt #(
    .Width    (32),
    .ResetVal (32'(POWERUP_CYCLES - 1))
  ) u_timeout_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load_q),
    .load_val (32'(TIMEOUT_CYCLES - 2)),
    .expire   (expire)
  );

  assign waiting   = state_q inside {StWaitTx, StWaitAck, StWaitBat, StWaitId};
  assign timed_out = waiting & expire & ~load_q;
  assign resend    = (state_q == StWaitAck) & link.rx_done & (link.rx_data == RSP_RESEND);

  // A received byte always takes priority over a simultaneous timeout.
  always_comb begin
    fail = 1'b0;
    unique case (state_q)
      StWaitTx:  fail = ~link.tx_done & ~link.rx_done & timed_out;
      StWaitAck: fail = link.rx_done ? (link.rx_data != RSP_ACK && link.rx_data != RSP_RESEND)
                                     : timed_out;
      StWaitBat: fail = link.rx_done ? (link.rx_data != RSP_BAT_OK) : timed_out;
      StWaitId:  fail = link.rx_done ? (link.rx_data != RSP_ID) : timed_out;
      default:   fail = 1'b0;
    endcase
  end

  assign give_up = (fail | resend) & (retry_q == RetryLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StPowerup;
      cmd_q        <= CMD_RESET;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      stream_en_q  <= 1'b0;
      init_error_q <= 1'b0;
      retry_q      <= '0;
      load_q       <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      load_q     <= waiting & link.rx_done;
      if (give_up) begin
        state_q      <= StError;
        retry_q      <= RetryMax;
        init_error_q <= 1'b1;
      end else if (fail | resend) begin
        state_q <= StSend;
        retry_q <= retry_q + 2'd1;
        if (fail) cmd_q <= CMD_RESET;
      end else begin
        unique case (state_q)
          StPowerup: if (expire) begin
            state_q <= StSend;
            cmd_q   <= CMD_RESET;
          end
          StSend: if (link.tx_ready) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= cmd_q;
            state_q    <= StWaitTx;
            load_q     <= 1'b1;
          end
          StWaitTx: if (link.tx_done) begin
            state_q <= StWaitAck;
            load_q  <= 1'b1;
          end
          StWaitAck: if (link.rx_done) begin
            if (cmd_q == CMD_RESET) begin
              state_q <= StWaitBat;
            end else begin
              state_q     <= StStream;
              stream_en_q <= 1'b1;
              retry_q     <= '0;
            end
          end
          StWaitBat: if (link.rx_done) state_q <= StWaitId;
          StWaitId: if (link.rx_done) begin
            state_q <= StSend;
            cmd_q   <= CMD_EN_STREAM;
          end
          StStream, StError: if (restart) begin
            state_q      <= StSend;
            cmd_q        <= CMD_RESET;
            retry_q      <= '0;
            stream_en_q  <= 1'b0;
            init_error_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign link.tx_start    = tx_start_q;
  assign link.tx_data     = tx_data_q;
  assign link.rx_done_pkt = link.rx_done & stream_en_q;
  assign stream_en        = stream_en_q;
  assign init_error       = init_error_q;
  assign retry_cnt        = retry_q;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Self-checking bench for ps2_mouse_ctrl: directed init scenarios plus a randomized device,
// all compared every cycle against a response-script model of the sequencer.
module tb_ps2_mouse_ctrl;

  localparam int P = 10;
  localparam int T = 100;
  localparam int R = 3;
  localparam int MPower = 0, MSend = 1, MTx = 2, MResp = 3, MStream = 4, MError = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       restart = 1'b0;
  logic       stream_en, init_error;
  logic [1:0] retry_cnt;

  ps2_mouse_ctrl_if link();

  ps2_mouse_ctrl #(
    .POWERUP_CYCLES (P),
    .TIMEOUT_CYCLES (T),
    .MAX_RETRY      (R)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .link       (link),
    .stream_en  (stream_en),
    .init_error (init_error),
    .retry_cnt  (retry_cnt)
  );

  int checks = 0;
  int errors = 0;
  int pkt_cnt = 0;
  bit rand_ready = 1'b0;

  // Model: mode, cycles spent waiting, and progress through the expected reply script.
  int         m_mode, m_age, m_retry, m_got;
  bit         m_moved;
  logic [7:0] m_cmd, m_tx_data;
  logic       m_tx_start;
  logic [7:0] reset_script [3] = '{8'hFA, 8'hAA, 8'h00};

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = MPower; m_age = 0; m_retry = 0; m_got = 0;
    m_cmd = 8'h00; m_tx_data = 8'h00; m_tx_start = 1'b0;
  endtask

  task automatic m_goto(input int mode);
    m_mode = mode; m_age = 0; m_moved = 1'b1;
  endtask

  task automatic m_retry_or_die(input bit full_restart);
    if (m_retry + 1 >= R) begin
      m_retry = R;
      m_goto(MError);
    end else begin
      m_retry++;
      if (full_restart) m_cmd = 8'hFF;
      m_goto(MSend);
    end
  endtask

  task automatic m_step();
    logic [7:0] want;
    int         len;
    m_moved = 1'b0;
    m_tx_start = 1'b0;
    len  = (m_cmd == 8'hFF) ? 3 : 1;
    want = (m_cmd == 8'hFF) ? reset_script[m_got] : 8'hFA;
    case (m_mode)
      MPower: if (m_age == P - 1) begin m_cmd = 8'hFF; m_goto(MSend); end
      MSend: if (link.tx_ready) begin
        m_tx_start = 1'b1; m_tx_data = m_cmd; m_got = 0; m_goto(MTx);
      end
      MTx: begin
        if (link.tx_done) m_goto(MResp);
        else if (!link.rx_done && m_age == T - 1) m_retry_or_die(1'b1);
      end
      MResp: begin
        if (link.rx_done) begin
          if (m_got == 0 && link.rx_data == 8'hFE) m_retry_or_die(1'b0);
          else if (link.rx_data == want) begin
            m_got++;
            if (m_got == len) begin
              if (m_cmd == 8'hFF) begin m_cmd = 8'hF4; m_goto(MSend); end
              else begin m_retry = 0; m_goto(MStream); end
            end
          end else m_retry_or_die(1'b1);
        end else if (m_age == T - 1) m_retry_or_die(1'b1);
      end
      default: if (restart) begin m_cmd = 8'hFF; m_retry = 0; m_goto(MSend); end
    endcase
    if (!m_moved) begin
      if (link.rx_done && (m_mode == MTx || m_mode == MResp)) m_age = 0;
      else m_age++;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    check("tx_start", 32'(link.tx_start), 32'(m_tx_start));
    check("tx_data", 32'(link.tx_data), 32'(m_tx_data));
    check("stream_en", 32'(stream_en), 32'(m_mode == MStream));
    check("init_error", 32'(init_error), 32'(m_mode == MError));
    check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    check("rx_done_pkt", 32'(link.rx_done_pkt), 32'(link.rx_done && m_mode == MStream));
    if (link.rx_done_pkt) pkt_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    link.tx_done = 1'b0;
    link.rx_done = 1'b0;
    restart = 1'b0;
    link.tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic expect_tx(input logic [7:0] want, input string name, input int want_n);
    int n;
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (link.tx_start) begin
        check({name, "_data"}, 32'(link.tx_data), 32'(want));
        if (want_n >= 0) check({name, "_latency"}, 32'(n), 32'(want_n));
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s: no tx_start within %0d cycles, expected %0h", name, n, want);
  endtask

  task automatic ack_tx();
    repeat ($urandom_range(0, 4)) tick();
    link.tx_done = 1'b1;
    tick();
  endtask

  task automatic send_rx(input logic [7:0] b);
    repeat ($urandom_range(0, 6)) tick();
    link.rx_data = b;
    link.rx_done = 1'b1;
    tick();
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 7))
      0, 1, 7: return 8'hFA;
      2:       return 8'hAA;
      3:       return 8'h00;
      4:       return 8'hFE;
      5:       return 8'hFC;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic nominal_tail();
    send_rx(8'hFA); send_rx(8'hAA); send_rx(8'h00);
    expect_tx(8'hF4, "enable", -1);
    ack_tx();
    send_rx(8'hFA);
    tick(); tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    int pkt_base;
    link.tx_ready = 1'b1; link.tx_done = 1'b0; link.rx_done = 1'b0; link.rx_data = 8'h00;
    repeat (3) tick();
    check("rst_tx_start", 32'(link.tx_start), 32'd0);
    check("rst_tx_data", 32'(link.tx_data), 32'h00);
    check("rst_stream_en", 32'(stream_en), 32'd0);
    check("rst_init_error", 32'(init_error), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    reset = 1'b0;

    // Nominal init: first FF after the power-up wait.
    expect_tx(8'hFF, "first_reset", P + 1);
    ack_tx();
    nominal_tail();
    check("nom_stream_en", 32'(stream_en), 32'd1);
    check("nom_retry", 32'(retry_cnt), 32'd0);
    check("nom_no_pkt_during_init", 32'(pkt_cnt), 32'd0);

    // Stream gating.
    pkt_base = pkt_cnt;
    send_rx(8'h08); send_rx(8'h05); send_rx(8'hFB);
    tick();
    check("stream_pkt_count", 32'(pkt_cnt - pkt_base), 32'd3);

    // Resend on the first FF.
    restart = 1'b1;
    expect_tx(8'hFF, "restart", 2);
    ack_tx();
    send_rx(8'hFE);
    expect_tx(8'hFF, "resend", -1);
    check("resend_retry", 32'(retry_cnt), 32'd1);
    ack_tx();
    nominal_tail();
    check("resend_stream_en", 32'(stream_en), 32'd1);
    check("resend_retry_clr", 32'(retry_cnt), 32'd0);

    // Timeouts to error.
    restart = 1'b1;
    expect_tx(8'hFF, "to_first", 2);
    ack_tx();
    expect_tx(8'hFF, "to_second", T + 1);
    check("to_retry1", 32'(retry_cnt), 32'd1);
    ack_tx();
    expect_tx(8'hFF, "to_third", T + 1);
    check("to_retry2", 32'(retry_cnt), 32'd2);
    ack_tx();
    repeat (T + 1) tick();
    check("to_init_error", 32'(init_error), 32'd1);
    check("to_retry3", 32'(retry_cnt), 32'd3);
    check("to_stream_en", 32'(stream_en), 32'd0);
    restart = 1'b1;
    expect_tx(8'hFF, "err_restart", 2);
    check("err_restart_retry", 32'(retry_cnt), 32'd0);
    check("err_restart_clr", 32'(init_error), 32'd0);

    // Bad BAT, then a clean sequence.
    ack_tx();
    send_rx(8'hFA);
    send_rx(8'hFC);
    expect_tx(8'hFF, "bat_retry", -1);
    check("bat_retry_cnt", 32'(retry_cnt), 32'd1);
    ack_tx();
    nominal_tail();
    check("bat_stream_en", 32'(stream_en), 32'd1);
    check("bat_retry_clr", 32'(retry_cnt), 32'd0);

    // Asynchronous reset while waiting for the ID byte.
    restart = 1'b1;
    expect_tx(8'hFF, "pre_reset", 2);
    ack_tx();
    send_rx(8'hFA);
    send_rx(8'hAA);
    #2 reset = 1'b1;
    #1;
    check("async_tx_data", 32'(link.tx_data), 32'h00);
    check("async_tx_start", 32'(link.tx_start), 32'd0);
    check("async_retry", 32'(retry_cnt), 32'd0);
    check("async_stream_en", 32'(stream_en), 32'd0);
    tick();
    reset = 1'b0;
    expect_tx(8'hFF, "post_reset", P + 1);

    // Randomized device behaviour.
    rand_ready = 1'b1;
    for (int it = 0; it < 50; it++) begin
      if (stream_en) repeat ($urandom_range(1, 4)) send_rx(8'($urandom));
      if (stream_en || init_error) restart = 1'b1;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 400) begin
        tick();
        n++;
        seen = link.tx_start || init_error || stream_en;
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL random_progress: no tx_start/stream/error within %0d cycles", n);
      end
      if (link.tx_start) begin
        if ($urandom_range(0, 9) != 0) ack_tx();
        repeat ($urandom_range(0, 3)) send_rx(pick_byte());
      end
      repeat ($urandom_range(0, T + 20)) tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
